// File: rtl/parity_tx_ctrl_pkg.sv
// Shared types and constants for the parity serial frame transmitter.
package parity_tx_ctrl_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/parity.sv
// Byte parity generator: even_odd=1 gives XOR of the data, 0 gives XNOR.
module parity
  import parity_tx_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic              even_odd,
  output logic              par_out
);

  assign par_out = even_odd ? (^data_in) : (~^data_in);

endmodule

// File: rtl/parity_tx_ctrl.sv
// UART-style frame transmitter: start, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Accepts one byte per frame through a valid/ready handshake.
module parity_tx_ctrl
  import parity_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              even_odd,
  input  logic              parity_en,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              par_bit
);

  localparam int          CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                par_calc;
  logic                xfer;
  logic                cnt_wrap;

  parity u_parity (
    .data_in  (data_in),
    .even_odd (even_odd),
    .par_out  (par_calc)
  );

  assign ready_out = (state_q == IDLE);
  assign xfer      = valid_in & ready_out;
  assign cnt_wrap  = (clk_cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    if (state_q == IDLE) begin
      if (xfer) begin
        state_d   = START;
        shift_d   = data_in;
        par_en_d  = parity_en;
        par_bit_d = par_calc;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else begin
      clk_cnt_d = cnt_wrap ? '0 : clk_cnt_q + 1'b1;
      // bit_cnt indexes data bits in DATA and stop bits in STOP
      if (cnt_wrap) begin
        case (state_q)
          START: begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
          DATA: begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == 3'd7) begin
              state_d   = par_en_q ? PARITY : STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          PARITY: begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end
          STOP: begin
            if (bit_cnt_q == STOP_LAST) state_d = IDLE;
            else                        bit_cnt_d = bit_cnt_q + 3'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Registered control and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign par_bit = par_bit_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Bench for parity_tx_ctrl: two instances (1 and 2 stop bits) share stimulus
// and are compared each cycle against a frame-list model.
module tb_parity_tx_ctrl;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       even_odd = 1'b0;
  logic       parity_en = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready1, tx1, busy1, par1;
  logic       ready2, tx2, busy2, par2;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  parity_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .even_odd(even_odd),
    .parity_en(parity_en), .valid_in(valid_in), .ready_out(ready1),
    .tx_out(tx1), .busy(busy1), .par_bit(par1)
  );

  parity_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .even_odd(even_odd),
    .parity_en(parity_en), .valid_in(valid_in), .ready_out(ready2),
    .tx_out(tx2), .busy(busy2), .par_bit(par2)
  );

  // Model: on acceptance, the whole frame is expanded into a per-cycle bit list
  logic [63:0] mframe [2];
  int          mlen [2] = '{0, 0};
  int          mpos [2] = '{0, 0};
  logic        mtx [2]   = '{1'b1, 1'b1};
  logic        mbusy [2] = '{1'b0, 1'b0};
  logic        mpar [2]  = '{1'b0, 1'b0};

  function automatic logic [63:0] build_frame(input logic [7:0] d, input logic eo,
                                              input logic pen, input int sb,
                                              output int len);
    logic        b [16];
    int          n;
    logic [63:0] f;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin b[n] = d[i]; n++; end
    if (pen) begin b[n] = eo ? (^d) : (~^d); n++; end
    for (int s = 0; s < sb; s++) begin b[n] = 1'b1; n++; end
    f = '1;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < C; c++) f[k*C + c] = b[k];
    len = n * C;
    return f;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mpos[m] = 0; mlen[m] = 0; mtx[m] = 1'b1; mbusy[m] = 1'b0; mpar[m] = 1'b0;
      end else begin
        if (!mbusy[m] && valid_in) begin
          mframe[m] = build_frame(data_in, even_odd, parity_en, m + 1, mlen[m]);
          mpos[m]   = 0;
          mpar[m]   = even_odd ? (^data_in) : (~^data_in);
        end
        if (mpos[m] < mlen[m]) begin
          mtx[m] = mframe[m][mpos[m]]; mbusy[m] = 1'b1; mpos[m]++;
        end else begin
          mtx[m] = 1'b1; mbusy[m] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx1",    32'(tx1),    32'(mtx[0]));
      chk("busy1",  32'(busy1),  32'(mbusy[0]));
      chk("ready1", 32'(ready1), 32'(!mbusy[0]));
      chk("par1",   32'(par1),   32'(mpar[0]));
      chk("tx2",    32'(tx2),    32'(mtx[1]));
      chk("busy2",  32'(busy2),  32'(mbusy[1]));
      chk("ready2", 32'(ready2), 32'(!mbusy[1]));
      chk("par2",   32'(par2),   32'(mpar[1]));
    end
  end

  logic rtx1 [128];
  logic rtx2 [128];
  logic rb1 [128];
  int   nb1, nb2;

  task automatic capture(input int n);
    nb1 = 0; nb2 = 0;
    for (int i = 0; i < n; i++) begin
      rtx1[i] = tx1; rtx2[i] = tx2; rb1[i] = busy1;
      nb1 += int'(busy1); nb2 += int'(busy2);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic eo, input logic pen, input int n);
    @(negedge clk);
    data_in = d; even_odd = eo; parity_en = pen; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    capture(n);
  endtask

  int ea5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_par", 32'(par1), 32'd0);
    rst = 1'b0;

    send(8'hA5, 1'b1, 1'b1, 52);
    for (int k = 0; k < 11; k++) chk($sformatf("a5_bit%0d", k), 32'(rtx1[4*k + 2]), ea5[k]);
    chk("a5_busy_len", nb1, 44);
    chk("a5_par", 32'(par1), 32'd0);

    send(8'h00, 1'b0, 1'b1, 52);
    chk("odd_par", 32'(par1), 32'd1);
    chk("odd_slot", 32'(rtx1[38]), 32'd1);
    chk("odd_d0", 32'(rtx1[6]), 32'd0);
    chk("odd_busy_len", nb1, 44);

    send(8'h01, 1'b1, 1'b0, 52);
    chk("np2_start", 32'(rtx2[2]), 32'd0);
    chk("np2_d0", 32'(rtx2[6]), 32'd1);
    chk("np2_d1", 32'(rtx2[10]), 32'd0);
    chk("np2_d7", 32'(rtx2[34]), 32'd0);
    chk("np2_stop_a", 32'(rtx2[36]), 32'd1);
    chk("np2_stop_b", 32'(rtx2[43]), 32'd1);
    chk("np2_busy_len", nb2, 44);
    chk("np1_busy_len", nb1, 40);

    // Back-to-back with inputs changed right after the first acceptance
    @(negedge clk);
    data_in = 8'h3C; even_odd = 1'b1; parity_en = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    data_in = 8'hC3; even_odd = 1'b0;
    nb1 = 0;
    for (int i = 0; i < 110; i++) begin
      rtx1[i] = tx1; rb1[i] = busy1;
      if (i == 60) valid_in = 1'b0;
      @(negedge clk);
    end
    chk("b2b_d0", 32'(rtx1[5]), 32'd0);
    chk("b2b_d2", 32'(rtx1[13]), 32'd1);
    chk("b2b_par1", 32'(rtx1[37]), 32'd0);
    chk("b2b_last_busy", 32'(rb1[43]), 32'd1);
    chk("b2b_gap", 32'(rb1[44]), 32'd0);
    chk("b2b_second", 32'(rb1[45]), 32'd1);
    chk("b2b_start2", 32'(rtx1[45]), 32'd0);
    chk("b2b_f2_d0", 32'(rtx1[50]), 32'd1);
    chk("b2b_f2_par", 32'(rtx1[82]), 32'd1);
    chk("b2b_par_bit", 32'(par1), 32'd1);

    // Reset during data bit 3, with valid_in also high
    send(8'h00, 1'b1, 1'b0, 18);
    rst = 1'b1; valid_in = 1'b1; data_in = 8'hFF; even_odd = 1'b1; parity_en = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx1), 32'd1);
    chk("mid_rst_ready", 32'(ready1), 32'd1);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    capture(52);
    chk("ff_start", 32'(rtx1[2]), 32'd0);
    chk("ff_d0", 32'(rtx1[6]), 32'd1);
    chk("ff_par", 32'(rtx1[38]), 32'd0);
    chk("ff_stop", 32'(rtx1[41]), 32'd1);
    chk("ff_busy_len", nb1, 44);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
